// File: rtl/sisc_fetch_unit.sv
// Instruction-fetch stage: holds PC/IR, reads instruction memory over req/ack, resolves branches.
// Latency: fetch_go -> imem_req next cycle; ack in the REQ cycle -> fetch_done two cycles after fetch_go.
// Backpressure: waits on imem_ack for up to TIMEOUT WAIT cycles, then aborts with a NOOP and a sticky error.
module sisc_fetch_unit #(
    parameter int                 ADDR_W   = 16,
    parameter int                 TIMEOUT  = 15,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              fetch_go,
    input  logic              br_eval,
    input  logic [3:0]        stat,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       ir,
    output logic [3:0]        opcode,
    output logic [3:0]        mm,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_done,
    output logic              br_taken,
    output logic              fetch_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_BNR = 4'd7;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic              taken_q, taken_d;
    logic              err_q, err_d;

    logic              br_cond;
    logic              br_hit;
    logic [ADDR_W-1:0] br_target;
    logic [7:0]        cnt_inc;

    // Request is decoded from state so an async reset drops it immediately.
    assign imem_req   = (state_q == S_REQ) || (state_q == S_WAIT);
    assign imem_addr  = pc_q;
    assign ir         = ir_q;
    assign opcode     = ir_q[31:28];
    assign mm         = ir_q[27:24];
    assign pc         = pc_q;
    assign fetch_done = done_q;
    assign br_taken   = taken_q;
    assign fetch_err  = err_q;

    assign cnt_inc = cnt_q + 8'd1;

    // Branch decision and target; pc_q already points past the branch instruction.
    always_comb begin
        br_cond   = |(ir_q[27:24] & stat);
        br_hit    = 1'b0;
        br_target = pc_q;
        case (ir_q[31:28])
            OP_BRA: begin
                br_hit    = br_cond;
                br_target = ir_q[ADDR_W-1:0];
            end
            OP_BRR: begin
                br_hit    = br_cond;
                br_target = pc_q + ADDR_W'({{16{ir_q[15]}}, ir_q[15:0]});
            end
            OP_BNE: begin
                br_hit    = !br_cond;
                br_target = ir_q[ADDR_W-1:0];
            end
            OP_BNR: begin
                br_hit    = !br_cond;
                br_target = pc_q + ADDR_W'({{16{ir_q[15]}}, ir_q[15:0]});
            end
            default: begin
                br_hit    = 1'b0;
                br_target = pc_q;
            end
        endcase
    end

    // Fetch FSM next-state: request, wait with timeout, capture, and branch redirect in IDLE.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        taken_d = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (fetch_go && br_eval) begin
                    // Conflicting commands: neither is honoured.
                    err_d = 1'b1;
                end else if (fetch_go) begin
                    state_d = S_REQ;
                end else if (br_eval && br_hit) begin
                    pc_d    = br_target;
                    taken_d = 1'b1;
                end
            end
            S_REQ: begin
                cnt_d = 8'd0;
                if (fetch_go || br_eval) err_d = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fetch_go || br_eval) err_d = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else if (cnt_inc == 8'(TIMEOUT)) begin
                    // Memory never answered: retire a NOOP, keep PC, flag the error.
                    ir_d    = 32'd0;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
            taken_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            taken_q <= taken_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit: reset, fetch, branches, timeout, wrap and protocol errors.
// Inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Memory ack timing is driven directly by the bench, so stall lengths are exact.
module tb_sisc_fetch_unit;

    logic        clk;
    logic        rst_f;
    logic        fetch_go;
    logic        br_eval;
    logic [3:0]  stat;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] pc;
    logic        fetch_done;
    logic        br_taken;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    sisc_fetch_unit #(.ADDR_W(16), .TIMEOUT(15), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_go   (fetch_go),
        .br_eval    (br_eval),
        .stat       (stat),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .pc         (pc),
        .fetch_done (fetch_done),
        .br_taken   (br_taken),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_f = 1'b0;
        #3;
        rst_f = 1'b1;
        tick();
    endtask

    // One fetch at exp_pc; ack arrives after 'delay' cycles of request.
    task automatic do_fetch(input string tag, input logic [15:0] exp_pc,
                            input logic [31:0] data, input int delay);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk({tag, "_req"},  {31'd0, imem_req}, 32'd1);
        chk({tag, "_addr"}, {16'd0, imem_addr}, {16'd0, exp_pc});
        for (int i = 0; i < delay; i++) tick();
        chk({tag, "_done_early"}, {31'd0, fetch_done}, 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk({tag, "_done"},  {31'd0, fetch_done}, 32'd1);
        chk({tag, "_ir"},    ir, data);
        chk({tag, "_pc"},    {16'd0, pc}, {16'd0, exp_pc + 16'd1});
        tick();
        chk({tag, "_done_1cyc"}, {31'd0, fetch_done}, 32'd0);
    endtask

    task automatic do_branch(input string tag, input logic [3:0] s,
                             input logic exp_taken, input logic [15:0] exp_pc);
        stat    = s;
        br_eval = 1'b1;
        tick();
        br_eval = 1'b0;
        chk({tag, "_taken"}, {31'd0, br_taken}, {31'd0, exp_taken});
        chk({tag, "_pc"},    {16'd0, pc}, {16'd0, exp_pc});
        tick();
        chk({tag, "_taken_1cyc"}, {31'd0, br_taken}, 32'd0);
    endtask

    initial begin
        int req_cycles;
        rst_f      = 1'b0;
        fetch_go   = 1'b0;
        br_eval    = 1'b0;
        stat       = 4'd0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        #12;
        chk("rst_pc",    {16'd0, pc}, 32'd0);
        chk("rst_ir",    ir, 32'd0);
        chk("rst_req",   {31'd0, imem_req}, 32'd0);
        chk("rst_done",  {31'd0, fetch_done}, 32'd0);
        chk("rst_taken", {31'd0, br_taken}, 32'd0);
        chk("rst_err",   {31'd0, fetch_err}, 32'd0);
        rst_f = 1'b1;
        tick();

        // Reset in the middle of a stalled fetch.
        do_fetch("pre", 16'h0000, 32'h1111_0000, 0);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        tick();
        tick();
        chk("midw_req_before", {31'd0, imem_req}, 32'd1);
        #2;
        rst_f = 1'b0;
        #1;
        chk("midw_req_drop", {31'd0, imem_req}, 32'd0);
        chk("midw_pc",       {16'd0, pc}, 32'd0);
        chk("midw_ir",       ir, 32'd0);
        @(posedge clk);
        #1;
        rst_f      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        chk("late_ack_ir",   ir, 32'd0);
        chk("late_ack_pc",   {16'd0, pc}, 32'd0);
        chk("late_ack_done", {31'd0, fetch_done}, 32'd0);
        chk("late_ack_req",  {31'd0, imem_req}, 32'd0);

        // Walk PC to 3 then the stalled fetch of 1A2B0005.
        do_fetch("n0", 16'h0000, 32'd0, 0);
        do_fetch("n1", 16'h0001, 32'd0, 0);
        do_fetch("n2", 16'h0002, 32'd0, 1);
        do_fetch("f1", 16'h0003, 32'h1A2B_0005, 3);
        chk("f1_opcode", {28'd0, opcode}, 32'h1);
        chk("f1_mm",     {28'd0, mm}, 32'hA);

        // BRA absolute: not taken with stat=0, taken with matching flag.
        do_fetch("bra", 16'h0004, 32'h4200_0040, 0);
        do_branch("bra_nt", 4'b0000, 1'b0, 16'h0005);
        do_branch("bra_t",  4'b0010, 1'b1, 16'h0040);

        // Jump to 0x000F, fetch BNR there, then branch back by 16.
        do_fetch("bra2", 16'h0040, 32'h4F00_000F, 0);
        do_branch("bra2_t", 4'b0001, 1'b1, 16'h000F);
        do_fetch("bnr", 16'h000F, 32'h7100_FFF0, 2);
        do_branch("bnr_t", 4'b0000, 1'b1, 16'h0000);
        chk("no_err_yet", {31'd0, fetch_err}, 32'd0);

        // Timeout: request held for the REQ cycle plus 15 WAIT cycles.
        do_fetch("tpre", 16'h0000, 32'h1234_5678, 0);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        req_cycles = 0;
        while (imem_req && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_ir",   ir, 32'd0);
        chk("to_err",  {31'd0, fetch_err}, 32'd1);
        chk("to_pc",   {16'd0, pc}, 32'h0001);
        chk("to_done", {31'd0, fetch_done}, 32'd1);
        tick();
        chk("to_done_1cyc", {31'd0, fetch_done}, 32'd0);
        chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);

        // Wrap from 0xFFFF and fetch_go issued while waiting.
        do_reset();
        chk("rst2_err", {31'd0, fetch_err}, 32'd0);
        do_fetch("wpre", 16'h0000, 32'h4F00_FFFF, 0);
        do_branch("wbra", 4'b1000, 1'b1, 16'hFFFF);
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        tick();
        fetch_go = 1'b1;
        tick();
        fetch_go = 1'b0;
        chk("proto_err",  {31'd0, fetch_err}, 32'd1);
        chk("proto_req",  {31'd0, imem_req}, 32'd1);
        chk("proto_addr", {16'd0, imem_addr}, 32'h0000_FFFF);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0000;
        tick();
        imem_ack   = 1'b0;
        chk("wrap_pc",   {16'd0, pc}, 32'd0);
        chk("wrap_done", {31'd0, fetch_done}, 32'd1);
        tick();
        chk("wrap_idle", {31'd0, imem_req}, 32'd0);

        // Simultaneous fetch_go and br_eval in IDLE are both ignored.
        do_reset();
        do_fetch("spre", 16'h0000, 32'h4F00_0020, 0);
        stat     = 4'b1111;
        fetch_go = 1'b1;
        br_eval  = 1'b1;
        tick();
        fetch_go = 1'b0;
        br_eval  = 1'b0;
        chk("both_err",   {31'd0, fetch_err}, 32'd1);
        chk("both_req",   {31'd0, imem_req}, 32'd0);
        chk("both_pc",    {16'd0, pc}, 32'h0001);
        chk("both_taken", {31'd0, br_taken}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
